// File: rtl/booth_uc.sv
// booth_uc: Moore control unit sequencing a radix-2 Booth multiplier datapath.
module booth_uc #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic q0,
    input  logic q_1,
    output logic CargaQ,
    output logic CargaM,
    output logic InicA,
    output logic CargaA,
    output logic Resta,
    output logic DesplazaA,
    output logic DesplazaQ,
    output logic Fin
);
    localparam int CW = $clog2(N + 1);
    typedef enum logic [2:0] {IDLE, LOAD, EVAL, ADD, SUB, SHIFT, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx, cnt_inc;
    assign cnt_inc = cnt + 1'b1;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
    always_comb begin
        state_nx = IDLE;
        cnt_nx   = cnt;
        case (state)
            IDLE:  state_nx = start ? LOAD : IDLE;
            LOAD: begin
                state_nx = EVAL;
                cnt_nx   = '0;
            end
            EVAL:  state_nx = ({q0, q_1} == 2'b10) ? SUB : ({q0, q_1} == 2'b01) ? ADD : SHIFT;
            ADD:   state_nx = SHIFT;
            SUB:   state_nx = SHIFT;
            SHIFT: begin
                cnt_nx   = cnt_inc;
                state_nx = (cnt_inc == CW'(N)) ? DONE : EVAL;
            end
            DONE:  state_nx = start ? DONE : IDLE;
            default: state_nx = IDLE;
        endcase
    end
    assign CargaQ    = state == LOAD;
    assign CargaM    = state == LOAD;
    assign InicA     = state == LOAD;
    assign CargaA    = state == ADD || state == SUB;
    assign Resta     = state == SUB;
    assign DesplazaA = state == SHIFT;
    assign DesplazaQ = state == SHIFT;
    assign Fin       = state == DONE;
endmodule

// File: tb/tb_booth_uc.sv
// tb_booth_uc: scoreboard bench for booth_uc with a small Q-register model feeding q0/q_1.
module tb_booth_uc;
    logic clk = 1'b0, reset = 1'b0, start = 1'b0, q0, q_1;
    logic CargaQ, CargaM, InicA, CargaA, Resta, DesplazaA, DesplazaQ, Fin;
    logic [7:0] outv;
    logic [3:0] mult = 4'b0, qreg = 4'b0;
    logic qm1 = 1'b0, force10 = 1'b0;
    logic [7:0] sb[$];
    int pass_cnt = 0, tot_cnt = 0;

    localparam logic [7:0] V_IDLE  = 8'b0000_0000;
    localparam logic [7:0] V_LOAD  = 8'b1110_0000;
    localparam logic [7:0] V_EVAL  = 8'b0000_0000;
    localparam logic [7:0] V_ADD   = 8'b0001_0000;
    localparam logic [7:0] V_SUB   = 8'b0001_1000;
    localparam logic [7:0] V_SHIFT = 8'b0000_0110;
    localparam logic [7:0] V_DONE  = 8'b0000_0001;

    booth_uc #(.N(4)) dut (
        .clk(clk), .reset(reset), .start(start), .q0(q0), .q_1(q_1),
        .CargaQ(CargaQ), .CargaM(CargaM), .InicA(InicA), .CargaA(CargaA),
        .Resta(Resta), .DesplazaA(DesplazaA), .DesplazaQ(DesplazaQ), .Fin(Fin)
    );

    assign outv = {CargaQ, CargaM, InicA, CargaA, Resta, DesplazaA, DesplazaQ, Fin};
    assign q0  = force10 ? 1'b1 : qreg[0];
    assign q_1 = force10 ? 1'b0 : qm1;

    always #5 clk = ~clk;

    // Q register model: the accumulator is not modelled, zeros enter the MSB.
    always @(posedge clk) begin
        if (CargaQ) begin
            qreg <= mult;
            qm1  <= 1'b0;
        end else if (DesplazaQ) begin
            qm1  <= qreg[0];
            qreg <= {1'b0, qreg[3:1]};
        end
    end

    // Full operation: expected output vectors are queued up front and popped one per edge.
    task automatic run_op(input string name, input logic [3:0] m, input bit f10, input bit tog, input int hold);
        logic [7:0] exp;
        logic [1:0] pr;
        int cyc = 0;
        mult = m;
        force10 = f10;
        sb.push_back(V_LOAD);
        for (int i = 0; i < 4; i++) begin
            pr = f10 ? 2'b10 : {m[i], (i == 0) ? 1'b0 : m[i-1]};
            sb.push_back(V_EVAL);
            if (pr == 2'b10) sb.push_back(V_SUB);
            if (pr == 2'b01) sb.push_back(V_ADD);
            sb.push_back(V_SHIFT);
        end
        for (int i = 0; i <= hold; i++) sb.push_back(V_DONE);
        @(negedge clk);
        start = 1'b1;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            exp = sb.pop_front();
            tot_cnt++;
            if (outv !== exp) $display("FAIL %s edge%0d: got %b want %b", name, cyc, outv, exp);
            else pass_cnt++;
            if (exp != V_DONE) start = tog ? 1'($urandom_range(0, 1)) : (hold > 0);
            else start = sb.size() > 0;
            cyc++;
        end
        sb.push_back(V_IDLE);
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        tot_cnt++;
        if (outv !== exp) $display("FAIL %s idle_after_done: got %b want %b", name, outv, exp);
        else pass_cnt++;
        force10 = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        start = 1'b1;
        #3;
        sb.push_back(V_IDLE);
        exp = sb.pop_front();
        tot_cnt++;
        if (outv !== exp) $display("FAIL reset_initial: got %b want %b", outv, exp);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(V_IDLE);
        exp = sb.pop_front();
        tot_cnt++;
        if (outv !== exp) $display("FAIL reset_start_ignored: got %b want %b", outv, exp);
        else pass_cnt++;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(V_IDLE);
        exp = sb.pop_front();
        tot_cnt++;
        if (outv !== exp) $display("FAIL reset_idle_hold: got %b want %b", outv, exp);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp;
        mult = 4'b0000;
        sb.push_back(V_LOAD);
        sb.push_back(V_EVAL);
        sb.push_back(V_SHIFT);
        sb.push_back(V_EVAL);
        sb.push_back(V_SHIFT);
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            exp = sb.pop_front();
            tot_cnt++;
            if (outv !== exp) $display("FAIL reset_mid_pre edge%0d: got %b want %b", c, outv, exp);
            else pass_cnt++;
        end
        #2 reset = 1'b0;
        #1;
        sb.push_back(V_IDLE);
        exp = sb.pop_front();
        tot_cnt++;
        if (outv !== exp) $display("FAIL reset_mid_async: got %b want %b", outv, exp);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        run_op("reset_mid_rerun", 4'b0000, 1'b0, 1'b0, 0);
    endtask

    task automatic test_all_zero();     run_op("all_zero", 4'b0000, 1'b0, 1'b0, 0); endtask
    task automatic test_mult_0110();    run_op("mult_0110", 4'b0110, 1'b0, 1'b0, 0); endtask
    task automatic test_force_sub();    run_op("force_sub", 4'b0000, 1'b1, 1'b0, 0); endtask
    task automatic test_done_hold();    run_op("done_hold", 4'b1011, 1'b0, 1'b0, 4); endtask
    task automatic test_start_toggle(); run_op("start_toggle", 4'b0110, 1'b0, 1'b1, 0); endtask
    task automatic test_back_to_back();
        run_op("b2b_a", 4'b1001, 1'b0, 1'b0, 0);
        run_op("b2b_b", 4'b1111, 1'b0, 1'b1, 0);
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_mult_0110();
        test_force_sub();
        test_done_hold();
        test_reset_mid();
        test_start_toggle();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule

// File: doc/booth_uc.md
BOOTH_UC -- requirements
Module: booth_uc

Interface
REQ-001 Parameter N, default 4, sets the number of Booth iterations (operand width in bits); legal range 2..8.
REQ-002 clk  input  1  Single system clock; all state changes on the rising edge.
REQ-003 reset  input  1  Asynchronous, active-low reset.
REQ-004 start  input  1  Operation request; sampled on the rising edge in IDLE and in DONE only.
REQ-005 q0  input  1  Multiplier register bit 0 (current LSB of Q).
REQ-006 q_1  input  1  Multiplier register appended bit q-1.
REQ-007 CargaQ  output  1  Load Q from the operand bus and clear q-1.
REQ-008 CargaM  output  1  Load the multiplicand register M.
REQ-009 InicA  output  1  Clear the accumulator A to zero.
REQ-010 CargaA  output  1  Load the adder/subtractor result into A.
REQ-011 Resta  output  1  Adder mode select: 1 = A-M, 0 = A+M; meaningful only while CargaA=1.
REQ-012 DesplazaA  output  1  Arithmetic shift right of A; A LSB feeds the Q MSB.
REQ-013 DesplazaQ  output  1  Shift right of Q; q0 feeds q-1.
REQ-014 Fin  output  1  Product valid and operation complete.

Function
REQ-015 The controller SHALL be a Moore FSM with states IDLE, LOAD, EVAL, ADD, SUB, SHIFT, DONE; every output SHALL decode from the state register only.
REQ-016 The block SHALL hold an iteration counter of ceil(log2(N+1)) bits, cleared in LOAD and incremented by 1 on leaving SHIFT.
REQ-017 IDLE: all outputs 0; start=1 -> LOAD, otherwise stay.
REQ-018 LOAD: CargaQ=CargaM=InicA=1 for exactly one cycle; unconditional -> EVAL.
REQ-019 EVAL: all outputs 0; {q0,q_1}=10 -> SUB, 01 -> ADD, 00 or 11 -> SHIFT.
REQ-020 SUB: CargaA=1, Resta=1 for one cycle -> SHIFT.
REQ-021 ADD: CargaA=1, Resta=0 for one cycle -> SHIFT.
REQ-022 SHIFT: DesplazaA=DesplazaQ=1 for one cycle; if the post-increment count equals N -> DONE, else -> EVAL.
REQ-023 DONE: Fin=1, all other outputs 0; start=0 -> IDLE; start=1 holds DONE (no automatic restart, no retrigger while start stays high).
REQ-024 start SHALL be ignored in LOAD, EVAL, ADD, SUB and SHIFT; the operation runs to completion.
REQ-025 Only one of CargaA, DesplazaA/DesplazaQ and the LOAD group SHALL be asserted in any cycle; DesplazaA and DesplazaQ always assert together.
REQ-026 Latency from the start-sampling edge to Fin=1 SHALL be 1+2N+k cycles, where k is the number of ADD/SUB iterations (0..N); for N=4 this ranges from 9 to 13 cycles.
REQ-027 Unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-028 reset=0 SHALL force IDLE, clear the counter and drive all outputs to 0 immediately, independent of clk, including mid-operation.
REQ-029 After reset rises, the first start=1 sampled in IDLE SHALL begin a fresh LOAD; no residual iteration count SHALL survive the reset.

Verification
REQ-030 N=4, start pulse at edge 0, {q0,q_1} held 00 -> LOAD after edge 0; SHIFT after edges 2,4,6,8; Fin=1 after edge 9; CargaA is never asserted.
REQ-031 N=4, multiplier 0110 ({q0,q_1} per EVAL = 00,10,11,01) -> SUB after edge 4, ADD after edge 9 with Resta=0; Fin=1 after edge 11.
REQ-032 N=4, {q0,q_1} forced 10 at every EVAL -> SUB with Resta=1 after edges 2,5,8,11; Fin=1 after edge 13.
REQ-033 start held high through DONE for 5 cycles, then low -> Fin stays 1 and there is no second LOAD; IDLE follows on the edge after start=0.
REQ-034 reset driven low asynchronously during the second SHIFT -> all outputs drop to 0 before the next edge; after release, start gives LOAD and a full 4-iteration run with the expected Fin timing.
REQ-035 start toggled during EVAL/ADD/SHIFT -> the state sequence and Fin timing are identical to the run with start held low.
